// File: rtl/ez8_pc_pkg.sv
// Shared definitions for the fetch-side program-counter sequencer.
// Holds default PC width / reset vector, the RUN/SQUASH state encoding
// and the redirect-kind enum used to resolve same-cycle requests.
// Optional feature macro used by this slice: PC_SEQ_STACK_ERR_EN.
package ez8_pc_pkg;

  localparam int PC_WIDTH_DEF     = 12;
  localparam int RESET_VECTOR_DEF = 0;

  // Sequencer FSM encoding; SQUASH marks the instruction in decode as dead.
  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_SQUASH = 1'b1;

  // Resolved control-flow action for the current cycle.
  typedef enum logic [2:0] {
    RK_NONE = 3'd0,
    RK_SKIP = 3'd1,
    RK_JUMP = 3'd2,
    RK_CALL = 3'd3,
    RK_RET  = 3'd4
  } redirect_kind_e;

endpackage

// File: rtl/pc_sequencer_return_stack.sv
// return_stack: circular hardware return stack for call/ret.
// Ports: clk, reset_n, push_i/pop_i (mutually exclusive), push_dat_i, top_o
//   (entry a pop returns), err_o (sticky over/underflow, PC_SEQ_STACK_ERR_EN).
// Push when full overwrites the oldest entry; pop when empty returns the stale
// entry at the wrapped pointer. With PC_SEQ_STACK_ERR_EN undefined, err_o is 0.
module return_stack #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_dat_i,
  output logic [WIDTH-1:0] top_o,
  output logic             err_o
);

  localparam int PTR_W = $clog2(DEPTH);

  // Entries are not reset: the pointer alone defines what is live.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [PTR_W-1:0] sp_top;

  // sp_q points at the next free slot; the most recent push sits one below.
  assign sp_top = sp_q - PTR_W'(1);
  assign top_o  = mem_q[sp_top];

  always_comb begin
    sp_d = sp_q;
    if (push_i)     sp_d = sp_q + PTR_W'(1);
    else if (pop_i) sp_d = sp_top;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sp_q <= '0;
    else          sp_q <= sp_d;
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[sp_q] <= push_dat_i;
  end

`ifdef PC_SEQ_STACK_ERR_EN
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [OCC_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;
  logic             full, empty;

  assign full  = (occ_q == OCC_W'(DEPTH));
  assign empty = (occ_q == '0);

  // Occupancy saturates: an overflowing push keeps the stack "full" and an
  // underflowing pop keeps it "empty" while the pointer itself wraps.
  always_comb begin
    occ_d = occ_q;
    err_d = err_q;
    if (push_i) begin
      if (full) err_d = 1'b1;
      else      occ_d = occ_q + OCC_W'(1);
    end else if (pop_i) begin
      if (empty) err_d = 1'b1;
      else       occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the PC, drives the sync instruction ROM address, squashes
//   the instruction after a taken skip/jump/call/ret, holds the return stack.
// Ports: clk, reset_n, stall, skip, jump_en, call_en, ret_en, target, instr_in
//   -> pc_out, instr_out, instr_valid, stack_err (needs PC_SEQ_STACK_ERR_EN).
// Decode holds instr at A while pc_out = A+1; every redirect costs one bubble.
module pc_sequencer
  import ez8_pc_pkg::*;
#(
  parameter int PC_WIDTH     = PC_WIDTH_DEF,
  parameter int INSTR_WIDTH  = 16,
  parameter int RESET_VECTOR = RESET_VECTOR_DEF,
  parameter int STACK_DEPTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   stall,
  input  logic                   skip,
  input  logic                   jump_en,
  input  logic                   call_en,
  input  logic                   ret_en,
  input  logic [PC_WIDTH-1:0]    target,
  input  logic [INSTR_WIDTH-1:0] instr_in,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  output logic                   stack_err
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [0:0]          state_q, state_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] stack_top;
  logic                qual;
  redirect_kind_e      kind;

  assign pc_out      = pc_q;
  assign instr_out   = instr_in;
  assign instr_valid = (state_q == ST_RUN);

  // Wraps naturally at 2^PC_WIDTH.
  assign pc_inc = pc_q + PC_WIDTH'(1);

  // Requests only count for a live instruction in a non-stalled cycle.
  assign qual = instr_valid && !stall;

  always_comb begin
    kind = RK_NONE;
    if (qual) begin
      if (ret_en)       kind = RK_RET;
      else if (call_en) kind = RK_CALL;
      else if (jump_en) kind = RK_JUMP;
      else if (skip)    kind = RK_SKIP;
    end
  end

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (!stall) begin
      pc_d    = pc_inc;
      state_d = ST_RUN;
      case (kind)
        RK_RET: begin
          pc_d    = stack_top;
          state_d = ST_SQUASH;
        end
        RK_CALL, RK_JUMP: begin
          pc_d    = target;
          state_d = ST_SQUASH;
        end
        // Sequential fetch continues; only the word at A+1 is discarded.
        RK_SKIP: state_d = ST_SQUASH;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q    <= PC_WIDTH'(RESET_VECTOR);
      state_q <= ST_SQUASH;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Return address is pc_q, i.e. the instruction after the call.
  return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (PC_WIDTH)
  ) u_return_stack (
    .clk        (clk),
    .reset_n    (reset_n),
    .push_i     (kind == RK_CALL),
    .pop_i      (kind == RK_RET),
    .push_dat_i (pc_q),
    .top_o      (stack_top),
    .err_o      (stack_err)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a synchronous ROM model whose word at
// address A is {4'hA, A}. Expected stack_err depends on PC_SEQ_STACK_ERR_EN.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall, skip, jump_en, call_en, ret_en;
  logic [11:0] target;
  logic [15:0] instr_in;
  logic [11:0] pc_out;
  logic [15:0] instr_out;
  logic        instr_valid;
  logic        stack_err;

  int errs   = 0;
  int checks = 0;

`ifdef PC_SEQ_STACK_ERR_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .skip        (skip),
    .jump_en     (jump_en),
    .call_en     (call_en),
    .ret_en      (ret_en),
    .target      (target),
    .instr_in    (instr_in),
    .pc_out      (pc_out),
    .instr_out   (instr_out),
    .instr_valid (instr_valid),
    .stack_err   (stack_err)
  );

  function automatic logic [15:0] rom(input logic [11:0] a);
    return {4'hA, a};
  endfunction

  // Synchronous ROM, holds its output while stalled.
  always @(posedge clk) if (!stall) instr_in <= rom(pc_out);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; stall = 1'b0; skip = 1'b0; jump_en = 1'b0;
    call_en = 1'b0; ret_en = 1'b0; target = '0;

    // Reset state and release
    repeat (2) cyc();
    chk("rst_pc", 32'(pc_out), 32'h000);
    chk("rst_valid", 32'(instr_valid), 0);
    chk("rst_err", 32'(stack_err), 0);
    reset_n = 1'b1;
    chk("first_valid", 32'(instr_valid), 0);
    cyc();
    chk("seq_pc1", 32'(pc_out), 32'h001);
    chk("seq_valid1", 32'(instr_valid), 1);
    chk("seq_instr0", 32'(instr_out), 32'(rom(12'h000)));
    cyc(); chk("seq_pc2", 32'(pc_out), 32'h002);
    cyc(); chk("seq_pc3", 32'(pc_out), 32'h003);

    // Skip at instr 0x005
    repeat (3) cyc();
    chk("pre_skip_pc", 32'(pc_out), 32'h006);
    skip = 1'b1;
    cyc();
    chk("skip_pc", 32'(pc_out), 32'h007);
    chk("skip_bubble", 32'(instr_valid), 0);
    chk("skip_instr6", 32'(instr_out), 32'(rom(12'h006)));
    cyc();  // skip still high during bubble: ignored
    chk("skip_ign_pc", 32'(pc_out), 32'h008);
    chk("skip_ign_valid", 32'(instr_valid), 1);
    chk("skip_instr7", 32'(instr_out), 32'(rom(12'h007)));
    skip = 1'b0;

    // Call at instr 0x010, then ret
    repeat (9) cyc();
    chk("pre_call_pc", 32'(pc_out), 32'h011);
    call_en = 1'b1; target = 12'h100;
    cyc();
    chk("call_pc", 32'(pc_out), 32'h100);
    chk("call_bubble", 32'(instr_valid), 0);
    call_en = 1'b0;
    cyc();
    chk("call_run", 32'(instr_valid), 1);
    chk("call_pc2", 32'(pc_out), 32'h101);
    ret_en = 1'b1;
    cyc();
    chk("ret_pc", 32'(pc_out), 32'h011);
    chk("ret_bubble", 32'(instr_valid), 0);
    ret_en = 1'b0;
    cyc();
    chk("ret_pc2", 32'(pc_out), 32'h012);
    chk("ret_instr", 32'(instr_out), 32'(rom(12'h011)));

    // Jump beats skip
    skip = 1'b1; jump_en = 1'b1; target = 12'h040;
    cyc();
    chk("jmp_pc", 32'(pc_out), 32'h040);
    chk("jmp_bubble", 32'(instr_valid), 0);
    skip = 1'b0; jump_en = 1'b0;
    cyc();
    chk("jmp_pc2", 32'(pc_out), 32'h041);
    chk("jmp_valid", 32'(instr_valid), 1);

    // Stall for 3 cycles with a jump request that must be ignored
    stall = 1'b1; jump_en = 1'b1; target = 12'h200;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("stall_pc", 32'(pc_out), 32'h041);
      chk("stall_valid", 32'(instr_valid), 1);
      chk("stall_instr", 32'(instr_out), 32'(rom(12'h040)));
    end
    stall = 1'b0; jump_en = 1'b0;
    cyc();
    chk("unstall_pc", 32'(pc_out), 32'h042);
    chk("unstall_instr", 32'(instr_out), 32'(rom(12'h041)));

    // PC wrap
    jump_en = 1'b1; target = 12'hFFE;
    cyc();
    jump_en = 1'b0;
    cyc();
    chk("wrap_pre", 32'(pc_out), 32'hFFF);
    cyc();
    chk("wrap_pc", 32'(pc_out), 32'h000);
    chk("wrap_valid", 32'(instr_valid), 1);

    // 9 nested calls: targets 0x300..0x308, each returns to target+1
    for (int i = 0; i < 9; i++) begin
      call_en = 1'b1; target = 12'h300 + 12'(i);
      cyc();
      call_en = 1'b0;
      cyc();
      if (i == 7) chk("ovf_err8", 32'(stack_err), 0);
    end
    chk("ovf_err9", 32'(stack_err), 32'(EXP_ERR));
    // Ninth push (0x308) overwrote the oldest slot and is now on top.
    ret_en = 1'b1;
    cyc();
    ret_en = 1'b0;
    chk("ovf_ret_pc", 32'(pc_out), 32'h308);
    chk("ovf_err_sticky", 32'(stack_err), 32'(EXP_ERR));
    cyc();

    // Asynchronous reset during the squash after a call
    call_en = 1'b1; target = 12'h123;
    cyc();
    call_en = 1'b0;
    chk("pre_rst_pc", 32'(pc_out), 32'h123);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_pc", 32'(pc_out), 32'h000);
    chk("arst_valid", 32'(instr_valid), 0);
    chk("arst_err", 32'(stack_err), 0);
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("post_rst_pc", 32'(pc_out), 32'h001);

    // Ret on empty stack after reset
    ret_en = 1'b1;
    cyc();
    ret_en = 1'b0;
    chk("unf_err", 32'(stack_err), 32'(EXP_ERR));
    chk("unf_bubble", 32'(instr_valid), 0);
    cyc();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
